// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the parity scheduler
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_serial_engine.sv
// rtl/parity_serial_engine.sv - bit-serial parity accumulator, one data bit per shift
module parity_serial_engine
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data,
    output logic              acc,
    output logic              last
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
            acc  <= PAR_EVEN;
        end else if (load) begin
            data <= load_data;
            cnt  <= '0;
            acc  <= PAR_EVEN;
        end else if (shift) begin
            acc <= acc ^ data[cnt[BIT_W-1:0]];
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High while the final bit is being folded in; the FSM leaves SHIFT on it.
    assign last = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/parity_sched.sv
// rtl/parity_sched.sv - round-robin scheduler sharing one serial parity engine
module parity_sched
    import parity_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_parity,
    output logic                      busy
);

    localparam int ID_W = $clog2(N_REQ);

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] grant_data;
    logic              load;
    logic              shift;
    logic [DATA_W-1:0] eng_data;
    logic              eng_acc;
    logic              eng_last;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_valid && req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_valid = 1'b1;
                grant_id    = wrap_idx(rr_ptr, k);
            end
        end
    end

    assign grant_data = req_data[int'(grant_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = SHIFT;
            SHIFT:   if (eng_last)    next_state = RESP;
            RESP:    if (rsp_ready)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        load      = 1'b0;
        shift     = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                load = grant_valid;
                if (grant_valid && !rst) req_ready[grant_id] = 1'b1;
            end
            SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            id_q   <= '0;
        end else if (load) begin
            rr_ptr <= wrap_idx(grant_id, 1);
            id_q   <= grant_id;
        end
    end

    parity_serial_engine #(
        .DATA_W (DATA_W)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (grant_data),
        .data      (eng_data),
        .acc       (eng_acc),
        .last      (eng_last)
    );

    // Response fields read zero outside RESP; engine state is frozen in RESP.
    assign rsp_id     = rsp_valid ? id_q : '0;
    assign rsp_data   = rsp_valid ? eng_data : '0;
    assign rsp_parity = rsp_valid & eng_acc;

endmodule

// File: tb/tb_parity_sched.sv
// tb/tb_parity_sched.sv - randomized self-checking bench with transaction-level model
module tb_parity_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_parity;
    logic            busy;

    always #5 clk = ~clk;

    parity_sched #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_parity (rsp_parity),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int            g_id[$];
    int            g_cyc[$];
    int            r_id[$];
    int            r_cyc[$];
    logic [DW-1:0] r_data[$];
    logic          r_par[$];

    bit            m_active = 1'b0;
    int            m_age    = 0;
    int            m_id     = 0;
    int            m_ptr    = 0;
    logic [DW-1:0] m_word   = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level reference: a word accepted at cycle T answers at T+DW+1.
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        cyc++;
        if (rst) begin
            check("rst_busy", busy, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_req_ready", req_ready, 0);
            m_active = 1'b0;
            m_ptr    = 0;
        end else begin
            g = m_active ? -1 : model_grant(req_valid, m_ptr);
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, m_active);
            check("rsp_valid", rsp_valid, m_active && m_age > DW);
            if (m_active && m_age > DW) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_word);
                check("rsp_parity", rsp_parity, ^m_word);
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    g_id.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                r_cyc.push_back(cyc);
                r_data.push_back(rsp_data);
                r_par.push_back(rsp_parity);
            end
            if (!m_active) begin
                if (g >= 0) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_id     = g;
                    m_word   = req_data[g*DW +: DW];
                    m_ptr    = (g + 1) % N;
                end
            end else if (m_age > DW) begin
                if (rsp_ready) m_active = 1'b0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [DW-1:0] word);
        bit ok = 1'b0;
        req_data[id*DW +: DW] = word;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("send_timeout", 0, 1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!busy && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    logic [DW-1:0] t2_words [4] = '{8'b01010001, 8'hFF, 8'h7F, 8'h00};
    logic          t2_par   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int n0, nr, ng;
        bit seen;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = 4'hF;
        #1;
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        send(0, 8'b01110001);
        wait_idle();
        check("t1_parity", r_par[$], 0);
        check("t1_id", r_id[$], 0);
        check("t1_latency", r_cyc[$] - g_cyc[$], 9);

        for (int i = 0; i < 4; i++) begin
            send(1, t2_words[i]);
            wait_idle();
            check("t2_data", r_data[$], t2_words[i]);
            check("t2_parity", r_par[$], t2_par[i]);
        end

        send(2, 8'h3C);
        wait_idle();
        send(2, 8'hC3);
        wait_idle();
        check("t6_grant_a", g_id[$-1], 2);
        check("t6_grant_b", g_id[$], 2);
        req_valid = 4'hF;
        #1;
        check("t6_ptr_wrap", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        wait_idle();

        rsp_ready = 1'b0;
        send(0, 8'hA5);
        req_valid[3] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t4_rsp_seen", seen, 1);
        n0 = r_id.size();
        repeat (5) begin
            check("t4_valid_hold", rsp_valid, 1);
            check("t4_data_hold", rsp_data, 8'hA5);
            check("t4_parity_hold", rsp_parity, 0);
            check("t4_id_hold", rsp_id, 0);
            check("t4_req_ready_low", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req_valid[3] = 1'b0;
        check("t4_one_handshake", r_id.size(), n0 + 1);
        wait_idle();

        nr = r_id.size();
        send(1, 8'h5A);
        tick();
        tick();
        tick();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("t5_busy_zero", busy, 0);
        check("t5_rsp_valid_zero", rsp_valid, 0);
        check("t5_req_ready_zero", req_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        check("t5_no_response", r_id.size(), nr);
        ng = g_id.size();
        repeat (50) tick();
        check("t3_grant_count", g_id.size() >= ng + 5, 1);
        if (g_id.size() >= ng + 5) begin
            check("t5_first_grant_req0", g_id[ng], 0);
            for (int k = 0; k < 5; k++) check("t3_grant_order", g_id[ng + k], k % N);
            for (int k = 0; k < 4; k++) check("t3_issue_spacing", g_cyc[ng + k + 1] - g_cyc[ng + k], 10);
        end
        req_valid = '0;
        wait_idle();

        nr = r_id.size();
        repeat (1500) begin
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        check("rand_activity", r_id.size() > nr + 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
